// File: rtl/ascon_dec_ctrl.sv
// ASCON-128 decryption control FSM: init, AD, ciphertext blocks, finalisation, tag check.
// Optional ASCON_DEC_ABORT_EN adds abort_i, which forces DONE with auth_ok_o cleared.
module ascon_dec_ctrl #(
    parameter int NB_BLOCKS = 4
) (
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic         start_i,
`ifdef ASCON_DEC_ABORT_EN
    input  logic         abort_i,
`endif
    input  logic         data_valid_i,
    output logic         data_ready_o,
    input  logic [127:0] tag_i,
    input  logic [127:0] tag_ref_i,
    output logic [3:0]   round_o,
    output logic         input_mode_o,
    output logic         en_reg_state_o,
    output logic         en_xor_key_b_o,
    output logic         en_xor_data_b_o,
    output logic         en_xor_key_e_o,
    output logic         en_xor_lsb_e_o,
    output logic         en_replace_data_o,
    output logic         en_plain_o,
    output logic         en_tag_o,
    output logic [2:0]   block_o,
    output logic         plain_valid_o,
    output logic         done_o,
    output logic         auth_ok_o
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_AD_WAIT,
        S_AD_PERM,
        S_CT_WAIT,
        S_CT_PERM,
        S_FIN_PERM,
        S_TAG_CMP,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_RND = 4'd11;
    localparam logic [2:0] LAST_BLK = 3'(NB_BLOCKS - 1);

    state_t     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [2:0] block_q, block_d;
    logic       auth_q, auth_d;
    logic       plain_valid_q;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q       <= S_IDLE;
            round_q       <= '0;
            block_q       <= '0;
            auth_q        <= 1'b0;
            plain_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            round_q       <= round_d;
            block_q       <= block_d;
            auth_q        <= auth_d;
            plain_valid_q <= en_plain_o;
        end
    end

    always_comb begin
        state_d           = state_q;
        round_d           = round_q;
        block_d           = block_q;
        auth_d            = auth_q;
        data_ready_o      = 1'b0;
        round_o           = '0;
        input_mode_o      = 1'b0;
        en_reg_state_o    = 1'b0;
        en_xor_key_b_o    = 1'b0;
        en_xor_data_b_o   = 1'b0;
        en_xor_key_e_o    = 1'b0;
        en_xor_lsb_e_o    = 1'b0;
        en_replace_data_o = 1'b0;
        en_plain_o        = 1'b0;
        en_tag_o          = 1'b0;
        done_o            = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_INIT;
                    round_d = '0;
                    block_d = '0;
                    auth_d  = 1'b0;
                end
            end
            S_INIT: begin
                round_o        = round_q;
                input_mode_o   = (round_q != 4'd0);
                en_reg_state_o = 1'b1;
                if (round_q == LAST_RND) begin
                    en_xor_key_e_o = 1'b1;
                    state_d        = S_AD_WAIT;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_AD_WAIT: begin
                data_ready_o = 1'b1;
                if (data_valid_i) begin
                    en_xor_data_b_o = 1'b1;
                    en_reg_state_o  = 1'b1;
                    input_mode_o    = 1'b1;
                    round_o         = 4'd6;
                    round_d         = 4'd7;
                    state_d         = S_AD_PERM;
                end
            end
            S_AD_PERM: begin
                round_o        = round_q;
                en_reg_state_o = 1'b1;
                input_mode_o   = 1'b1;
                if (round_q == LAST_RND) begin
                    en_xor_lsb_e_o = 1'b1;
                    block_d        = '0;
                    state_d        = S_CT_WAIT;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_CT_WAIT: begin
                data_ready_o = 1'b1;
                if (data_valid_i) begin
                    en_replace_data_o = 1'b1;
                    en_plain_o        = 1'b1;
                    en_reg_state_o    = 1'b1;
                    input_mode_o      = 1'b1;
                    // The last block goes straight into the 12-round finalisation.
                    if (block_q == LAST_BLK) begin
                        en_xor_key_b_o = 1'b1;
                        round_o        = 4'd0;
                        round_d        = 4'd1;
                        state_d        = S_FIN_PERM;
                    end else begin
                        round_o = 4'd6;
                        round_d = 4'd7;
                        state_d = S_CT_PERM;
                    end
                end
            end
            S_CT_PERM: begin
                round_o        = round_q;
                en_reg_state_o = 1'b1;
                input_mode_o   = 1'b1;
                if (round_q == LAST_RND) begin
                    block_d = block_q + 3'd1;
                    state_d = S_CT_WAIT;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_FIN_PERM: begin
                round_o        = round_q;
                en_reg_state_o = 1'b1;
                input_mode_o   = 1'b1;
                if (round_q == LAST_RND) begin
                    en_xor_key_e_o = 1'b1;
                    en_tag_o       = 1'b1;
                    state_d        = S_TAG_CMP;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_TAG_CMP: begin
                auth_d  = (tag_i == tag_ref_i);
                state_d = S_DONE;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef ASCON_DEC_ABORT_EN
        if (abort_i && state_q != S_IDLE && state_q != S_DONE) begin
            state_d           = S_DONE;
            round_d           = round_q;
            block_d           = block_q;
            auth_d            = 1'b0;
            data_ready_o      = 1'b0;
            round_o           = '0;
            input_mode_o      = 1'b0;
            en_reg_state_o    = 1'b0;
            en_xor_key_b_o    = 1'b0;
            en_xor_data_b_o   = 1'b0;
            en_xor_key_e_o    = 1'b0;
            en_xor_lsb_e_o    = 1'b0;
            en_replace_data_o = 1'b0;
            en_plain_o        = 1'b0;
            en_tag_o          = 1'b0;
        end
`endif
    end

    assign block_o       = block_q;
    assign plain_valid_o = plain_valid_q;
    assign auth_ok_o     = auth_q;

endmodule

// File: tb/tb_ascon_dec_ctrl.sv
// Scoreboard bench for ascon_dec_ctrl: round sequence, plaintext pulses,
// done timing and authentication result under stalls, ignored starts and reset.
module tb_ascon_dec_ctrl;

    logic         clock_i = 1'b0;
    logic         resetb_i;
    logic         start_i;
    logic         abort_i;
    logic         data_valid_i;
    logic         data_ready_o;
    logic [127:0] tag_i;
    logic [127:0] tag_ref_i;
    logic [3:0]   round_o;
    logic         input_mode_o;
    logic         en_reg_state_o;
    logic         en_xor_key_b_o;
    logic         en_xor_data_b_o;
    logic         en_xor_key_e_o;
    logic         en_xor_lsb_e_o;
    logic         en_replace_data_o;
    logic         en_plain_o;
    logic         en_tag_o;
    logic [2:0]   block_o;
    logic         plain_valid_o;
    logic         done_o;
    logic         auth_ok_o;

    localparam logic [127:0] TAG = 128'h0123456789ABCDEF0123456789ABCDEF;

    ascon_dec_ctrl #(.NB_BLOCKS(4)) dut (
        .clock_i          (clock_i),
        .resetb_i         (resetb_i),
        .start_i          (start_i),
`ifdef ASCON_DEC_ABORT_EN
        .abort_i          (abort_i),
`endif
        .data_valid_i     (data_valid_i),
        .data_ready_o     (data_ready_o),
        .tag_i            (tag_i),
        .tag_ref_i        (tag_ref_i),
        .round_o          (round_o),
        .input_mode_o     (input_mode_o),
        .en_reg_state_o   (en_reg_state_o),
        .en_xor_key_b_o   (en_xor_key_b_o),
        .en_xor_data_b_o  (en_xor_data_b_o),
        .en_xor_key_e_o   (en_xor_key_e_o),
        .en_xor_lsb_e_o   (en_xor_lsb_e_o),
        .en_replace_data_o(en_replace_data_o),
        .en_plain_o       (en_plain_o),
        .en_tag_o         (en_tag_o),
        .block_o          (block_o),
        .plain_valid_o    (plain_valid_o),
        .done_o           (done_o),
        .auth_ok_o        (auth_ok_o)
    );

    always #5 clock_i = ~clock_i;

    int cyc = 0;
    always @(posedge clock_i) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int auth;
    } done_t;

    int    rq[$];
    int    pq[$];
    done_t dq[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    done_cnt;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int all_outs();
        return int'({data_ready_o, round_o, input_mode_o, en_reg_state_o,
                     en_xor_key_b_o, en_xor_data_b_o, en_xor_key_e_o,
                     en_xor_lsb_e_o, en_replace_data_o, en_plain_o, en_tag_o,
                     block_o, plain_valid_o, done_o, auth_ok_o});
    endfunction

    task automatic push_exp(input int s, input int abort_at, input logic match);
        int cut;
        int c;
        done_t d;
        cut = (abort_at >= 0) ? abort_at : 1000;
        for (int i = 0; i < 12; i++)
            if (1 + i < cut) rq.push_back(i);
        for (int i = 6; i < 12; i++)
            if (7 + i < cut) rq.push_back(i);
        for (int b = 0; b < 3; b++)
            for (int i = 6; i < 12; i++) begin
                c = 19 + 6 * b + ((b >= 1) ? s : 0) + i - 6;
                if (c < cut) rq.push_back(i);
            end
        for (int i = 0; i < 12; i++)
            if (37 + s + i < cut) rq.push_back(i);
        if (abort_at < 0)
            for (int b = 0; b < 4; b++) pq.push_back(b);
        d.cyc  = (abort_at >= 0) ? abort_at + 1 : 50 + s;
        d.auth = (abort_at < 0 && match) ? 1 : 0;
        dq.push_back(d);
    endtask

    task automatic sample(input int n, input int s, input bit nominal);
        done_t d;
        if (en_reg_state_o) begin
            if (rq.size() == 0) check("round_extra", 1, 0);
            else check("round", int'(round_o), rq.pop_front());
        end
        if (plain_valid_o) begin
            if (pq.size() == 0) check("plain_extra", 1, 0);
            else check("plain_blk", int'(block_o), pq.pop_front());
        end
        if (done_o) begin
            done_cnt++;
            if (dq.size() == 0) check("done_extra", 1, 0);
            else begin
                d = dq.pop_front();
                check("done_cyc", n, d.cyc);
                check("auth", int'(auth_ok_o), d.auth);
            end
        end
        if (s > 0 && n >= 25 && n < 25 + s) begin
            check("stall_rdy", int'(data_ready_o), 1);
            check("stall_en", int'(en_reg_state_o), 0);
        end
        if (nominal) begin
            if (n == 1) check("imode0", int'(input_mode_o), 0);
            if (n == 2) check("imode1", int'(input_mode_o), 1);
            if (n == 12) check("xke_init", int'(en_xor_key_e_o), 1);
            if (n == 18) check("xlsb", int'(en_xor_lsb_e_o), 1);
            if (n == 37 + s) check("xkb", int'(en_xor_key_b_o), 1);
            if (n == 48 + s) check("tag_en", int'(en_tag_o), 1);
        end
    endtask

    task automatic run(input logic [127:0] tref, input int s,
                       input int pulse_at, input int rst_at,
                       input int abort_at);
        int t0;
        int len;
        bit aborted;
        tag_ref_i = tref;
        done_cnt  = 0;
        aborted   = 0;
        push_exp(s, abort_at, tref == TAG);
        len = ((abort_at >= 0) ? abort_at + 1 : 50 + s) + 4;
        @(negedge clock_i);
        t0 = cyc;
        for (int k = 0; k < len; k++) begin
            int n;
            n = cyc - t0;
            start_i      = (n == 0) || (n == pulse_at);
            data_valid_i = !(s > 0 && n >= 25 && n < 25 + s);
            abort_i      = (n == abort_at);
            if (n == rst_at) begin
                resetb_i = 1'b0;
                #1;
                check("rst_outs", all_outs(), 0);
                rq.delete();
                pq.delete();
                dq.delete();
                aborted = 1;
                break;
            end
            #1;
            sample(n, s, abort_at < 0);
            @(negedge clock_i);
        end
        start_i      = 1'b0;
        abort_i      = 1'b0;
        data_valid_i = 1'b1;
        if (!aborted) begin
            check("rounds_left", rq.size(), 0);
            check("plain_left", pq.size(), 0);
            check("done_left", dq.size(), 0);
            check("done_cnt", done_cnt, 1);
        end else begin
            @(negedge clock_i);
            resetb_i = 1'b1;
        end
    endtask

    initial begin
        resetb_i     = 1'b0;
        start_i      = 1'b0;
        abort_i      = 1'b0;
        data_valid_i = 1'b1;
        tag_i        = TAG;
        tag_ref_i    = TAG;
        repeat (3) @(negedge clock_i);
        check("reset_outs", all_outs(), 0);
        resetb_i = 1'b1;
        @(negedge clock_i);
        check("idle_outs", all_outs(), 0);

        run(TAG, 0, -1, -1, -1);
        run(TAG ^ 128'h1, 0, -1, -1, -1);
        check("auth_hold", int'(auth_ok_o), 0);
        run(TAG, 5, -1, -1, -1);
        check("auth_hold1", int'(auth_ok_o), 1);
        run(TAG, 0, 20, -1, -1);
        run(TAG, 0, -1, 42, -1);
        check("post_rst", all_outs(), 0);
        run(TAG, 0, -1, -1, -1);
`ifdef ASCON_DEC_ABORT_EN
        run(TAG, 0, -1, -1, 15);
        check("abort_idle", int'(done_o), 0);
`endif
        repeat (2) @(negedge clock_i);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ascon_dec_ctrl.md
Name: ascon_dec_ctrl

Overview:
- Control FSM for the ASCON-128 decryption path; it is the receive-side counterpart of the encryption controller and drives the same permutation/state datapath.
- Sequences initialisation, associated-data absorption, ciphertext-to-plaintext blocks and finalisation, and contains its own round and block counters.
- Compares the recomputed tag with the received tag and reports authentication success or failure.
- Ciphertext, associated data and the received tag come from the host-side interface through a valid/ready handshake.

Parameters:
- NB_BLOCKS, 4, number of 64-bit ciphertext blocks per message, including the last one. Legal range 2..8.

Ports:
- clock_i  in  1  system clock
- resetb_i  in  1  reset, asynchronous, active-low
- start_i  in  1  start request; sampled only in IDLE
- data_valid_i  in  1  host has an AD/ciphertext block on the data bus
- data_ready_o  out  1  controller accepts a block this cycle
- tag_i  in  128  tag register output from the datapath
- tag_ref_i  in  128  received tag, stable from start to done
- round_o  out  4  round-constant index sent to the permutation
- input_mode_o  out  1  0 = load initial state, 1 = feed back the state register
- en_reg_state_o  out  1  state register enable
- en_xor_key_b_o, en_xor_data_b_o, en_xor_key_e_o, en_xor_lsb_e_o  out  1 each  XOR enables at the permutation input (b) or output (e)
- en_replace_data_o  out  1  replace the rate word with the ciphertext (decrypt mode)
- en_plain_o  out  1  capture plaintext = ciphertext XOR rate
- en_tag_o  out  1  capture the tag
- block_o  out  3  current ciphertext block index
- plain_valid_o  out  1  plaintext register valid; 1-cycle pulse
- done_o  out  1  1-cycle completion pulse
- auth_ok_o  out  1  tag match result; held until the next start

Behaviour:
- Reset: state IDLE. All outputs 0, including round_o, block_o and auth_ok_o.
- States and transitions:
  - IDLE: on start_i=1, go to INIT. auth_ok_o is cleared on this transition.
  - INIT: 12 cycles, round_o = 0..11.
    - Cycle 0: input_mode_o=0.
    - Later cycles: input_mode_o=1.
    - en_reg_state_o=1 on every cycle.
    - Round 11: en_xor_key_e_o=1, then go to AD_WAIT.
  - AD_WAIT: data_ready_o=1.
    - Handshake is data_valid_i=1 in the same cycle as data_ready_o=1.
    - On handshake: en_xor_data_b_o=1, en_reg_state_o=1, input_mode_o=1, round_o=6, go to AD_PERM.
    - With no valid: hold, with all enables at 0.
  - AD_PERM: round_o = 7..11, en_reg_state_o=1, input_mode_o=1.
    - Round 11: en_xor_lsb_e_o=1 (domain separation).
    - Then block counter = 0 and go to CT_WAIT.
  - CT_WAIT: data_ready_o=1. block_o = the block counter.
    - If block < NB_BLOCKS-1, on handshake: en_replace_data_o=1, en_plain_o=1, en_reg_state_o=1, input_mode_o=1, round_o=6, go to CT_PERM.
    - If block = NB_BLOCKS-1, on handshake: same as above plus en_xor_key_b_o=1, but round_o=0, and go to FIN_PERM.
  - CT_PERM: round_o = 7..11. At round 11, increment the block counter and return to CT_WAIT.
  - FIN_PERM: round_o = 1..11, en_reg_state_o=1, input_mode_o=1.
    - Round 11: en_xor_key_e_o=1, en_tag_o=1.
  - TAG_CMP: 1 cycle. auth_ok_o <= (tag_i == tag_ref_i), a full 128-bit compare.
  - DONE: done_o=1 for 1 cycle, then go to IDLE.
- plain_valid_o: asserted the cycle after each en_plain_o.
- Round counter: 4-bit. Reloaded on every state entry (0 for INIT, 6 at the AD/CT handshake, 0 at the final handshake). Never wraps past 11.
- Latency: start_i sampled in cycle 0, no stalls, NB_BLOCKS=4 gives done_o in cycle 50 (1+12+6+18+12+1).
- Stalls: data_valid_i low in a WAIT state stretches that state only; the state register is not enabled while waiting.
- Simultaneous and ignored events:
  - start_i outside IDLE is ignored.
  - data_valid_i outside the WAIT states is ignored, and data_ready_o is 0 there.
- Reset mid-operation: immediate return to IDLE with all outputs 0. A partial result is never reported.

Optional Feature:
- Macro: ASCON_DEC_ABORT_EN.
- Defined: adds input abort_i (1 bit).
  - abort_i=1 in any state other than IDLE/DONE forces DONE on the next cycle: done_o=1, auth_ok_o=0, no further enables.
  - abort_i has priority over every other transition.
- Undefined: port absent and the FSM is unchanged.

Test Plan:
- NB_BLOCKS=4, data_valid_i tied 1, tag_ref_i = tag_i = 0x0123..CDEF -> rounds 0..11/6..11/0..11 in order; done_o exactly at cycle 50; auth_ok_o=1; 4 plain_valid_o pulses.
- Same run, but tag_ref_i differs from tag_i in bit 0 -> auth_ok_o=0 at done; the plaintext pulses are unchanged.
- data_valid_i held 0 for 5 cycles in CT_WAIT of block 1 -> data_ready_o stays 1, en_reg_state_o=0 while waiting, done_o at cycle 55.
- start_i pulsed during CT_PERM -> no effect; a single done_o is produced.
- resetb_i low during FIN_PERM round 5 -> all outputs 0 asynchronously; a new start gives a clean 50-cycle run.
- With ASCON_DEC_ABORT_EN, abort_i in AD_PERM -> done_o next cycle, auth_ok_o=0, then IDLE.
